// File: rtl/matrix_pkg.sv
// Shared matrix-unit definitions: default geometry of the result matrix and
// the readout FSM state encoding used by the multiplier, result RAM and reader.
package matrix_pkg;

    localparam int MAT_DEPTH  = 64;
    localparam int MAT_DATA_W = 19;
    localparam int MAT_ADDR_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } reader_state_t;

endpackage

// File: rtl/result_skid_buf.sv
// Two-entry FIFO between the result RAM read port and the streaming output.
// The head entry never moves while it is not popped, so stalled outputs stay stable.
module result_skid_buf #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_headData,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rdPtr;
    logic             r_wrPtr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // Entry storage is cleared on reset so the streamed outputs read as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rdPtr  <= 1'b0;
            r_wrPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clear) begin
            r_rdPtr  <= 1'b0;
            r_wrPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= i_pushData;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    assign o_headData = r_mem[r_rdPtr];
    assign o_count    = r_count;

endmodule

// File: rtl/result_reader.sv
// Streams every word of the external result RAM, in address order, over a
// valid/ready interface while accumulating a signed checksum of the pass.
module result_reader
    import matrix_pkg::*;
#(
    parameter int DEPTH  = MAT_DEPTH,
    parameter int DATA_W = MAT_DATA_W,
    parameter int ADDR_W = MAT_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        rd_data,
    output logic [DATA_W-1:0]        out_data,
    output logic [ADDR_W-1:0]        out_index,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W+ADDR_W-1:0] checksum
);

    localparam int BUF_W  = DATA_W + ADDR_W + 1;
    localparam int CSUM_W = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    reader_state_t     r_state;
    reader_state_t     w_nextState;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_inflightAddr;
    logic              r_inflight;
    logic [CSUM_W-1:0] r_checksum;

    logic [BUF_W-1:0]  w_pushData;
    logic [BUF_W-1:0]  w_headData;
    logic [1:0]        w_count;
    logic [DATA_W-1:0] w_headWord;
    logic [ADDR_W-1:0] w_headIdx;
    logic              w_headLast;
    logic              w_active;
    logic              w_start;
    logic              w_outValid;
    logic              w_pop;
    logic              w_issueOk;
    logic              w_rdEn;

    assign w_active   = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign w_start    = start && !w_active;
    assign {w_headLast, w_headIdx, w_headWord} = w_headData;
    assign w_outValid = w_active && (w_count != 2'd0);
    assign w_pop      = w_outValid && out_ready;

    // A read is only issued if its word is guaranteed a free buffer slot on arrival.
    assign w_issueOk  = (3'(w_count) + 3'(r_inflight) - 3'(w_pop)) < 3'd2;
    assign w_rdEn     = (r_state == ST_READ) && w_issueOk;
    assign w_pushData = {(r_inflightAddr == LAST_ADDR), r_inflightAddr, rd_data};

    result_skid_buf #(
        .WIDTH(BUF_W)
    ) u_skidBuf (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_start),
        .i_push    (r_inflight),
        .i_pushData(w_pushData),
        .i_pop     (w_pop),
        .o_headData(w_headData),
        .o_count   (w_count)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_nextState = ST_READ;
            ST_READ:  if (w_rdEn && (r_addr == LAST_ADDR)) w_nextState = ST_DRAIN;
            ST_DRAIN: if (w_pop && w_headLast) w_nextState = ST_DONE;
            ST_DONE:  if (start) w_nextState = ST_READ;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // A fresh pass clears the address counter and checksum; the buffer clears alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_inflight     <= 1'b0;
            r_inflightAddr <= '0;
            r_checksum     <= '0;
        end else begin
            r_state        <= w_nextState;
            r_inflight     <= w_rdEn;
            r_inflightAddr <= r_addr;
            if (w_start) begin
                r_addr     <= '0;
                r_checksum <= '0;
            end else begin
                if (w_rdEn) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_checksum <= r_checksum + {{ADDR_W{w_headWord[DATA_W-1]}}, w_headWord};
                end
            end
        end
    end

    assign rd_en     = w_rdEn;
    assign rd_addr   = r_addr;
    assign out_data  = w_headWord;
    assign out_index = w_headIdx;
    assign out_valid = w_outValid;
    assign out_last  = w_outValid && w_headLast;
    assign busy      = w_active;
    assign done      = (r_state == ST_DONE);
    assign checksum  = r_checksum;

endmodule

// File: tb/tb_result_reader.sv
// Self-checking bench for result_reader: a behavioural RAM plus an in-order
// word/checksum model derived directly from the RAM contents.
module tb_result_reader;

    localparam int DEPTH  = 64;
    localparam int DATA_W = 19;
    localparam int ADDR_W = 6;
    localparam int CSUM_W = DATA_W + ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [CSUM_W-1:0] checksum;

    int ramWords [DEPTH];
    int nChecks = 0;
    int nFails  = 0;

    result_reader #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_data (out_data),
        .out_index(out_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= DATA_W'(ramWords[rd_addr]);
    end

    function automatic longint dataVal(input logic [DATA_W-1:0] d);
        return longint'($signed(d));
    endfunction

    function automatic longint csumVal(input logic [CSUM_W-1:0] c);
        return longint'($signed(c));
    endfunction

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_rdEn"},     rd_en,     0);
        checkOutput({tag, "_rdAddr"},   rd_addr,   0);
        checkOutput({tag, "_outValid"}, out_valid, 0);
        checkOutput({tag, "_outLast"},  out_last,  0);
        checkOutput({tag, "_outIndex"}, out_index, 0);
        checkOutput({tag, "_outData"},  dataVal(out_data), 0);
        checkOutput({tag, "_busy"},     busy,      0);
        checkOutput({tag, "_done"},     done,      0);
        checkOutput({tag, "_checksum"}, csumVal(checksum), 0);
    endtask

    // One readout pass. Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input int readyPct, input bit holdOff, input bit midStart,
                                 input int abortAt);
        longint            expSum;
        int                accepted;
        int                readsIssued;
        int                firstValid;
        int                lastSeenAt;
        int                doneAt;
        bit                pop;
        bit                prevValid;
        bit                prevReady;
        logic [DATA_W-1:0] prevData;
        logic [ADDR_W-1:0] prevIdx;
        logic              prevLast;

        expSum = 0;
        foreach (ramWords[i]) expSum += ramWords[i];
        accepted    = 0;
        readsIssued = 0;
        firstValid  = -1;
        lastSeenAt  = -1;
        doneAt      = -1;
        prevValid   = 1'b0;
        prevReady   = 1'b0;
        prevData    = '0;
        prevIdx     = '0;
        prevLast    = 1'b0;

        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b0;

        for (int n = 1; n <= 2000 && doneAt < 0; n++) begin
            @(negedge clk);
            if (abortAt >= 0 && accepted == abortAt + 1) begin
                reset = 1'b1;
                #1;
                checkIdle("abort");
                @(negedge clk);
                reset = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    checkOutput("abortNoValid", out_valid, 0);
                    checkOutput("abortNoBusy", busy, 0);
                end
                return;
            end
            if (n == 1) start = 1'b0;
            if (midStart && n == 6) start = 1'b1;
            if (midStart && n == 7) start = 1'b0;
            out_ready = (holdOff && n <= 10) ? 1'b0 : ($urandom_range(99) < readyPct);
            #1;
            if (n == 1) begin
                checkOutput("startBusy", busy, 1);
                checkOutput("startDoneLow", done, 0);
            end
            if (done) begin
                doneAt = n;
            end else begin
                pop = out_valid && out_ready;
                if (prevValid && !prevReady) begin
                    checkOutput("stallValid", out_valid, 1);
                    checkOutput("stallData", dataVal(out_data), dataVal(prevData));
                    checkOutput("stallIndex", out_index, prevIdx);
                    checkOutput("stallLast", out_last, prevLast);
                end
                if (rd_en) begin
                    checkOutput("rdAddr", rd_addr, readsIssued);
                    checkOutput("rdRoom", (readsIssued - accepted - int'(pop)) < 2, 1);
                    readsIssued++;
                end
                if (out_valid) begin
                    if (firstValid < 0) begin
                        firstValid = n;
                        checkOutput("firstValidCycle", n, 3);
                    end
                    checkOutput("outIndex", out_index, accepted);
                    checkOutput("outData", dataVal(out_data),
                                (accepted < DEPTH) ? ramWords[accepted] : -1);
                    checkOutput("outLast", out_last, accepted == DEPTH - 1);
                    if (pop) begin
                        if (out_last) lastSeenAt = n;
                        accepted++;
                    end
                end
                if (holdOff && n == 10) begin
                    checkOutput("holdReads", readsIssued <= 2, 1);
                    checkOutput("holdIndex", out_index, 0);
                    checkOutput("holdData", dataVal(out_data), ramWords[0]);
                end
                prevValid = out_valid;
                prevReady = out_ready;
                prevData  = out_data;
                prevIdx   = out_index;
                prevLast  = out_last;
            end
        end

        checkOutput("passDone", done, 1);
        checkOutput("doneLatency", doneAt - lastSeenAt, 1);
        checkOutput("wordsAccepted", accepted, DEPTH);
        checkOutput("readsIssued", readsIssued, DEPTH);
        checkOutput("checksum", csumVal(checksum), expSum);
        checkOutput("doneBusy", busy, 0);
        checkOutput("doneValid", out_valid, 0);

        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("doneHeld", done, 1);
        checkOutput("checksumHeld", csumVal(checksum), expSum);
        checkOutput("doneRdEn", rd_en, 0);
        checkOutput("doneValidHeld", out_valid, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        rd_data   = '0;
        foreach (ramWords[i]) ramWords[i] = i - 32;

        // Start is held high across an edge while reset is asserted and must be ignored.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        #1;
        checkIdle("reset");
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("postResetBusy", busy, 0);

        $display("[TB] pass: ramp words, ready high");
        applyStimulus(100, 1'b0, 1'b0, -1);
        checkOutput("rampChecksum", csumVal(checksum), -32);

        $display("[TB] pass: all max positive");
        foreach (ramWords[i]) ramWords[i] = 262143;
        applyStimulus(100, 1'b0, 1'b0, -1);
        checkOutput("maxPosChecksum", csumVal(checksum), 16777152);

        $display("[TB] pass: all max negative");
        foreach (ramWords[i]) ramWords[i] = -262144;
        applyStimulus(100, 1'b0, 1'b0, -1);
        checkOutput("maxNegChecksum", csumVal(checksum), -16777216);

        $display("[TB] pass: random words, random ready, start pulsed while busy");
        foreach (ramWords[i]) ramWords[i] = int'($urandom_range(524287)) - 262144;
        applyStimulus(50, 1'b0, 1'b1, -1);

        $display("[TB] pass: restart from done with identical contents");
        applyStimulus(100, 1'b0, 1'b0, -1);

        $display("[TB] pass: consumer stalled for ten cycles");
        applyStimulus(100, 1'b1, 1'b0, -1);

        $display("[TB] pass: reset after word 20, then fresh pass");
        applyStimulus(70, 1'b0, 1'b0, 20);
        foreach (ramWords[i]) ramWords[i] = int'($urandom_range(524287)) - 262144;
        applyStimulus(100, 1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of result words per matrix.
REQ-002 SHALL have parameter DATA_W, default 19, signed result word width.
REQ-003 SHALL have parameter ADDR_W, default 6, result RAM address width (log2 DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin one full readout pass; sampled in IDLE or DONE only.
REQ-007 SHALL have port rd_en  output  1  result RAM read strobe.
REQ-008 SHALL have port rd_addr  output  ADDR_W  result RAM read address.
REQ-009 SHALL have port rd_data  input  DATA_W  RAM read data, valid exactly 1 cycle after rd_en.
REQ-010 SHALL have port out_data  output  DATA_W  streamed result word.
REQ-011 SHALL have port out_index  output  ADDR_W  RAM address of the word on out_data.
REQ-012 SHALL have port out_valid  output  1  out_data/out_index/out_last valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-014 SHALL have port out_last  output  1  high with word index DEPTH-1.
REQ-015 SHALL have port busy  output  1  high in READ and DRAIN.
REQ-016 SHALL have port done  output  1  level, high in DONE.
REQ-017 SHALL have port checksum  output  DATA_W+ADDR_W  signed sum of all words accepted this pass.

Function
REQ-018 SHALL implement FSM IDLE -> READ -> DRAIN -> DONE; DONE -> READ on start.
REQ-019 SHALL move IDLE/DONE -> READ on a clock edge with start=1, clearing address counter, buffer, checksum, done.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL issue rd_en with incrementing rd_addr 0..DEPTH-1, each address exactly once per pass.
REQ-022 SHALL hold a 2-entry output buffer; SHALL assert rd_en only when occupancy + reads in flight - (pop this cycle) < 2 (no overflow, no data loss).
REQ-023 SHALL capture rd_data into the buffer on the edge after rd_en, tagged with its address.
REQ-024 SHALL transfer a word exactly on edges where out_valid=1 and out_ready=1.
REQ-025 SHALL hold out_data/out_index/out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL present words in ascending address order.
REQ-027 SHALL, with out_ready held high, produce first out_valid 2 cycles after the start edge and one word per cycle thereafter (DEPTH words in DEPTH+2 cycles).
REQ-028 SHALL go READ -> DRAIN after issuing address DEPTH-1; DRAIN -> DONE on the edge accepting out_last.
REQ-029 SHALL add each accepted word, sign-extended, to checksum on the accepting edge; no wrap possible at DATA_W+ADDR_W bits.
REQ-030 SHALL keep checksum and done stable in DONE until next start or reset.
REQ-031 SHALL keep rd_en=0 and out_valid=0 in IDLE and DONE.

Reset
REQ-032 SHALL on reset=1, regardless of clock, force state IDLE, rd_en=0, rd_addr=0, out_valid=0, out_last=0, out_index=0, out_data=0, busy=0, done=0, checksum=0, buffer empty.
REQ-033 SHALL abort a pass mid-stream on reset; no word emitted until a new start.
REQ-034 SHALL ignore start on the first edge while reset is still asserted.

Structure
REQ-035 SHALL place DATA_W, ADDR_W, DEPTH defaults and FSM state encodings in the shared matrix package used by the multiplier and result RAM.
REQ-036 SHALL implement the 2-entry buffer as sub-module result_skid_buf (DATA_W+ADDR_W+1 wide, push/pop/count).
REQ-037 SHALL instantiate no RAM; the result RAM is external and single-read-port.

Verification
REQ-038 SHALL check: RAM word i = i-32, out_ready=1, start pulse -> 64 words, index 0..63, first out_valid 2 cycles after start, out_last with index 63, done next cycle, checksum = -32.
REQ-039 SHALL check: all words 18'h3FFFF-style max positive 262143 -> checksum 16777152, no overflow; all -262144 -> checksum -16777216.
REQ-040 SHALL check: out_ready random 50% -> same 64 ordered words, no duplicate/drop, outputs stable while stalled, rd_en never raised with buffer+in-flight = 2.
REQ-041 SHALL check: out_ready low for 10 cycles after start -> at most 2 rd_en issued, out_data = word 0 held.
REQ-042 SHALL check: reset asserted after word 20 accepted -> all outputs zero immediately; new start -> words restart at index 0, checksum covers new pass only.
REQ-043 SHALL check: start pulsed in READ -> ignored; start in DONE -> done drops, second identical pass produced.
